// File: rtl/pseudo_sensor_frame_gen.sv
// Pseudo sensor frame generator: emits a raster test pattern (x + y + frame_cnt)
// with sof/eol/eof framing, horizontal and vertical blanking.
// Optional sink backpressure via the PSG_BACKPRESSURE_EN macro (adds pix_ready).
module pseudo_sensor_frame_gen #(
    parameter int H_ACTIVE = 32,
    parameter int V_ACTIVE = 32,
    parameter int H_BLANK  = 8,
    parameter int V_BLANK  = 16,
    parameter int PIX_W    = 8
) (
    input  logic             p_clk,
    input  logic             arst_p_n,
    input  logic             run,
`ifdef PSG_BACKPRESSURE_EN
    input  logic             pix_ready,
`endif
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic [7:0]       frame_cnt,
    output logic             busy
);

    localparam int XW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int CW   = $clog2(BMAX + 1);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] X_PEN  = XW'(H_ACTIVE - 2);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] H_END  = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] V_END  = CW'(V_BLANK - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t          state;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    logic [CW-1:0]   bcnt;
    logic            accept;
    logic [PIX_W-1:0] data_next_x;
    logic [PIX_W-1:0] data_next_line;
    logic [PIX_W-1:0] data_first;

`ifdef PSG_BACKPRESSURE_EN
    assign accept = pix_ready;
`else
    assign accept = 1'b1;
`endif

    // Pattern value of each candidate next beat; outputs are registered, so the
    // value is computed for the beat about to be presented, not the current one.
    always_comb begin
        data_next_x    = PIX_W'(32'(x) + 32'(y) + 32'(frame_cnt) + 32'd1);
        data_next_line = PIX_W'(32'(y) + 32'(frame_cnt) + 32'd1);
        data_first     = PIX_W'(frame_cnt);
    end

    // Frame FSM with raster counters and registered beat outputs.
    always_ff @(posedge p_clk or negedge arst_p_n) begin
        if (!arst_p_n) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            bcnt      <= '0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            sof       <= 1'b0;
            eol       <= 1'b0;
            eof       <= 1'b0;
            frame_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state     <= ACTIVE;
                        x         <= '0;
                        y         <= '0;
                        busy      <= 1'b1;
                        pix_valid <= 1'b1;
                        sof       <= 1'b1;
                        eol       <= 1'b0;
                        eof       <= 1'b0;
                        pix_data  <= data_first;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (x == X_LAST) begin
                            if (y == Y_LAST) begin
                                state     <= VBLANK;
                                bcnt      <= '0;
                                x         <= '0;
                                y         <= '0;
                                frame_cnt <= frame_cnt + 8'd1;
                                pix_valid <= 1'b0;
                                pix_data  <= '0;
                                sof       <= 1'b0;
                                eol       <= 1'b0;
                                eof       <= 1'b0;
                            end else if (H_BLANK == 0) begin
                                x         <= '0;
                                y         <= y + YW'(1);
                                sof       <= 1'b0;
                                eol       <= 1'b0;
                                eof       <= 1'b0;
                                pix_data  <= data_next_line;
                            end else begin
                                state     <= HBLANK;
                                bcnt      <= '0;
                                x         <= '0;
                                pix_valid <= 1'b0;
                                pix_data  <= '0;
                                sof       <= 1'b0;
                                eol       <= 1'b0;
                                eof       <= 1'b0;
                            end
                        end else begin
                            x        <= x + XW'(1);
                            sof      <= 1'b0;
                            eol      <= (x == X_PEN);
                            eof      <= (x == X_PEN) && (y == Y_LAST);
                            pix_data <= data_next_x;
                        end
                    end
                end
                HBLANK: begin
                    if (bcnt == H_END) begin
                        state     <= ACTIVE;
                        x         <= '0;
                        y         <= y + YW'(1);
                        pix_valid <= 1'b1;
                        pix_data  <= data_next_line;
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                VBLANK: begin
                    if (bcnt == V_END) begin
                        bcnt <= '0;
                        if (run) begin
                            state     <= ACTIVE;
                            pix_valid <= 1'b1;
                            sof       <= 1'b1;
                            pix_data  <= data_first;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        bcnt <= bcnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pseudo_sensor_frame_gen.sv
// Self-checking bench for pseudo_sensor_frame_gen. The reference model tracks
// only the position inside the frame period and derives every output from it.
// Backpressure scenarios are compiled only with PSG_BACKPRESSURE_EN.
module tb_pseudo_sensor_frame_gen;

    localparam int H       = 4;
    localparam int V       = 3;
    localparam int HB      = 2;
    localparam int VB      = 5;
    localparam int PW      = 8;
    localparam int LINE    = H + HB;
    localparam int ACT_LEN = V * LINE - HB;
    localparam int PERIOD  = ACT_LEN + VB;

    logic          p_clk = 1'b0;
    logic          arst_p_n = 1'b0;
    logic          run = 1'b0;
`ifdef PSG_BACKPRESSURE_EN
    logic          pix_ready = 1'b1;
`endif
    logic          pix_valid;
    logic [PW-1:0] pix_data;
    logic          sof;
    logic          eol;
    logic          eof;
    logic [7:0]    frame_cnt;
    logic          busy;

    int total = 0;
    int bad   = 0;

    // reference model state: in-frame flag, position in period, completed frames
    bit m_act;
    int m_p;
    int m_fc;

    logic [20:0] obs;
    assign obs = {pix_valid, sof, eol, eof, busy, (pix_valid ? pix_data : 8'h00), frame_cnt};

    pseudo_sensor_frame_gen #(
        .H_ACTIVE(H),
        .V_ACTIVE(V),
        .H_BLANK (HB),
        .V_BLANK (VB),
        .PIX_W   (PW)
    ) dut (
        .p_clk    (p_clk),
        .arst_p_n (arst_p_n),
        .run      (run),
`ifdef PSG_BACKPRESSURE_EN
        .pix_ready(pix_ready),
`endif
        .pix_valid(pix_valid),
        .pix_data (pix_data),
        .sof      (sof),
        .eol      (eol),
        .eof      (eof),
        .frame_cnt(frame_cnt),
        .busy     (busy)
    );

    always #5 p_clk = ~p_clk;

    function automatic logic [20:0] exp_vec();
        int  x;
        int  y;
        logic v;
        x = m_p % LINE;
        y = m_p / LINE;
        v = m_act && (m_p < ACT_LEN) && (x < H);
        return {v, v && (m_p == 0), v && (x == H - 1), v && (m_p == ACT_LEN - 1),
                m_act ? 1'b1 : 1'b0, (v ? 8'((x + y + m_fc) % 256) : 8'h00), 8'(m_fc)};
    endfunction

    function automatic bit stalled();
`ifdef PSG_BACKPRESSURE_EN
        logic [20:0] e;
        e = exp_vec();
        return e[20] && !pix_ready;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_act = 1'b0;
        m_p   = 0;
        m_fc  = 0;
    endtask

    task automatic model_step(input logic r);
        if (!m_act) begin
            if (r) begin
                m_act = 1'b1;
                m_p   = 0;
            end
        end else if (m_p == PERIOD - 1) begin
            if (r) m_p = 0;
            else   m_act = 1'b0;
        end else begin
            m_p++;
            if (m_p == ACT_LEN) m_fc = (m_fc + 1) % 256;
        end
    endtask

    // one clock: DUT and model both take the edge, then settle to mid-cycle
    task automatic advance();
        bit st;
        st = stalled();
        @(posedge p_clk);
        if (!st) model_step(run);
        @(negedge p_clk);
    endtask

    task automatic do_reset();
        run = 1'b0;
`ifdef PSG_BACKPRESSURE_EN
        pix_ready = 1'b1;
`endif
        arst_p_n = 1'b0;
        model_reset();
        repeat (2) @(negedge p_clk);
        arst_p_n = 1'b1;
    endtask

    task automatic test_reset();
        run = 1'b1;
        arst_p_n = 1'b0;
        model_reset();
        @(negedge p_clk);
        total++;
        if (obs !== 21'h0) begin
            bad++;
            $display("FAIL reset_outputs: got=%h exp=%h", obs, 21'h0);
        end
        run = 1'b0;
        arst_p_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            advance();
            total++;
            if (obs !== exp_vec() || pix_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle_no_beat cyc=%0d: got=%h exp=%h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_frames();
        int sof_cyc[$];
        int eol_beats[$];
        int data_q[$];
        int exp_tab[12] = '{0, 1, 2, 3, 1, 2, 3, 4, 2, 3, 4, 5};
        int eof_n;
        int beat;
        do_reset();
        run   = 1'b1;
        eof_n = 0;
        beat  = 0;
        for (int c = 0; c < 2 * PERIOD + 1; c++) begin
            advance();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL frames_cycle cyc=%0d: got=%h exp=%h", c, obs, exp_vec());
            end
            if (pix_valid === 1'b1) begin
                if (sof === 1'b1) begin
                    sof_cyc.push_back(c);
                    beat = 0;
                end
                beat++;
                data_q.push_back(int'(pix_data));
                if (eol === 1'b1 && sof_cyc.size() == 1) eol_beats.push_back(beat);
                if (eof === 1'b1) begin
                    eof_n++;
                    total++;
                    if (beat != 12) begin
                        bad++;
                        $display("FAIL frames_eof_beat: got=%0d exp=12", beat);
                    end
                end
            end
        end
        total++;
        if (sof_cyc.size() != 3) begin
            bad++;
            $display("FAIL frames_sof_count: got=%0d exp=3", sof_cyc.size());
        end else if (sof_cyc[1] - sof_cyc[0] != 21 || sof_cyc[2] - sof_cyc[1] != 21) begin
            bad++;
            $display("FAIL frames_period: got=%0d,%0d exp=21", sof_cyc[1] - sof_cyc[0], sof_cyc[2] - sof_cyc[1]);
        end
        total++;
        if (eol_beats.size() != 3) begin
            bad++;
            $display("FAIL frames_eol_count: got=%0d exp=3", eol_beats.size());
        end else if (eol_beats[0] != 4 || eol_beats[1] != 8 || eol_beats[2] != 12) begin
            bad++;
            $display("FAIL frames_eol_pos: got=%0d,%0d,%0d exp=4,8,12", eol_beats[0], eol_beats[1], eol_beats[2]);
        end
        total++;
        if (eof_n != 2) begin
            bad++;
            $display("FAIL frames_eof_count: got=%0d exp=2", eof_n);
        end
        total++;
        if (data_q.size() != 25) begin
            bad++;
            $display("FAIL frames_beat_count: got=%0d exp=25", data_q.size());
        end else begin
            for (int i = 0; i < 24; i++) begin
                total++;
                if (data_q[i] != exp_tab[i % 12] + i / 12) begin
                    bad++;
                    $display("FAIL frames_pattern beat=%0d: got=%0d exp=%0d", i, data_q[i], exp_tab[i % 12] + i / 12);
                end
            end
        end
    endtask

    task automatic test_single_run();
        int beats;
        do_reset();
        run   = 1'b1;
        beats = 0;
        for (int c = 0; c < 41; c++) begin
            advance();
            run = 1'b0;
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL single_cycle cyc=%0d: got=%h exp=%h", c, obs, exp_vec());
            end
            if (pix_valid === 1'b1) beats++;
        end
        total++;
        if (beats != 12 || busy !== 1'b0 || frame_cnt !== 8'd1) begin
            bad++;
            $display("FAIL single_frame: got beats=%0d busy=%b fc=%0d exp beats=12 busy=0 fc=1", beats, busy, frame_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        bit found;
        do_reset();
        run   = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 50 && !found; c++) begin
            advance();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL midrst_cycle cyc=%0d: got=%h exp=%h", c, obs, exp_vec());
            end
            if (m_act && m_p == LINE + 2) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL midrst_timeout: got=no_beat exp=beat_x2_y1");
        end
        #2 arst_p_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== 21'h0) begin
            bad++;
            $display("FAIL midrst_async_clear: got=%h exp=%h", obs, 21'h0);
        end
        #1 arst_p_n = 1'b1;
        advance();
        total++;
        if (obs !== exp_vec() || sof !== 1'b1 || pix_data !== 8'd0) begin
            bad++;
            $display("FAIL midrst_restart: got=%h exp=%h", obs, exp_vec());
        end
    endtask

`ifdef PSG_BACKPRESSURE_EN
    task automatic test_backpressure();
        int sof_cyc[$];
        logic [PW-1:0] held;
        do_reset();
        run = 1'b1;
        for (int k = 0; k < 27; k++) begin
            advance();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL bp_cycle k=%0d: got=%h exp=%h", k, obs, exp_vec());
            end
            if (k == 2) held = pix_data;
            if (k >= 2 && k <= 5) begin
                total++;
                if (pix_valid !== 1'b1 || pix_data !== held || pix_data !== 8'd2) begin
                    bad++;
                    $display("FAIL bp_hold k=%0d: got=%0d exp=2", k, pix_data);
                end
            end
            if (pix_valid === 1'b1 && sof === 1'b1) sof_cyc.push_back(k);
            pix_ready = !(k >= 2 && k <= 4);
        end
        total++;
        if (sof_cyc.size() != 2 || sof_cyc[1] - sof_cyc[0] != 24) begin
            bad++;
            $display("FAIL bp_period: got sofs=%0d exp period=24", sof_cyc.size());
        end
    endtask
`endif

    task automatic test_wrap();
        int eof_edges;
        bit prev_eof;
        bit wrapped;
        logic [7:0] prev_fc;
        do_reset();
        run       = 1'b1;
        eof_edges = 0;
        prev_eof  = 1'b0;
        wrapped   = 1'b0;
        prev_fc   = 8'd0;
        for (int c = 0; c < 300 * PERIOD; c++) begin
            advance();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL wrap_cycle cyc=%0d: got=%h exp=%h", c, obs, exp_vec());
            end
            if (eof === 1'b1 && !prev_eof) eof_edges++;
            prev_eof = (eof === 1'b1);
            if (prev_fc == 8'd255 && frame_cnt === 8'd0) wrapped = 1'b1;
            prev_fc = frame_cnt;
        end
        total++;
        if (eof_edges != 300 || !wrapped || frame_cnt !== 8'd44) begin
            bad++;
            $display("FAIL wrap_summary: got eofs=%0d wrapped=%0d fc=%0d exp eofs=300 wrapped=1 fc=44",
                     eof_edges, wrapped, frame_cnt);
        end
    endtask

    task automatic test_random_run();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            run = ($urandom_range(0, 3) != 0);
`ifdef PSG_BACKPRESSURE_EN
            pix_ready = ($urandom_range(0, 3) != 0);
`endif
            advance();
            total++;
            if (obs !== exp_vec()) begin
                bad++;
                $display("FAIL random_cycle cyc=%0d: got=%h exp=%h", c, obs, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_frames();
        test_single_run();
        test_reset_midframe();
`ifdef PSG_BACKPRESSURE_EN
        test_backpressure();
`endif
        test_wrap();
        test_random_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
